mac_layer_ctrl: RTL and testbench

Sequencer for the 64-lane Q8.8 `mac` datapath; computes one fully-connected layer.
- For each output neuron, it clears the MAC and streams all input/weight chunks from synchronous-read memories.
- It then waits out the MAC's output register, applies optional ReLU, and writes the neuron result to the output buffer.
- It sits between the top-level layer scheduler (start/done) and the `mac` instance plus its three buffers.

---
 rtl/nn_pkg.sv | 22 ++
 rtl/mac_layer_ctrl.sv | 152 +++++++++++++++
 tb/tb_mac_layer_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nn_pkg : shared types and constants for the NN accelerator blocks  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package nn_pkg;

  localparam int MAC_LANES       = 64;
  localparam int MAC_FRAC_BITS   = 8;
  localparam int MAC_OUT_LATENCY = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } mac_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_layer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mac_layer_ctrl : sequences one fully-connected layer on the MAC    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mac_layer_ctrl
  import nn_pkg::*;
#(
  parameter int NUM_CHUNKS  = 13,
  parameter int NUM_NEURONS = 64,
  parameter int CHUNK_AW    = 4,
  parameter int WEIGHT_AW   = 10,
  parameter int OUT_AW      = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  relu_en,
  output logic                  busy,
  output logic                  done,
  output logic [CHUNK_AW-1:0]   in_rd_addr,
  output logic [WEIGHT_AW-1:0]  w_rd_addr,
  output logic                  mac_reset,
  output logic                  mac_zero,
  input  logic signed [15:0]    mac_result,
  output logic                  out_wr_en,
  output logic [OUT_AW-1:0]     out_wr_addr,
  output logic signed [15:0]    out_wr_data
);

  localparam logic [CHUNK_AW-1:0] LAST_CHUNK  = CHUNK_AW'(NUM_CHUNKS - 1);
  localparam logic [OUT_AW-1:0]   LAST_NEURON = OUT_AW'(NUM_NEURONS - 1);

  mac_ctrl_state_t       state_q, state_d;
  logic [CHUNK_AW-1:0]   chunk_q, chunk_d;
  logic [OUT_AW-1:0]     neuron_q, neuron_d;
  logic                  relu_q, relu_d;
  logic [CHUNK_AW-1:0]   in_addr_q, in_addr_d;
  logic [WEIGHT_AW-1:0]  w_addr_q, w_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wr_en_q, wr_en_d;
  logic                  mac_reset_q, mac_reset_d;
  logic                  mac_zero_q, mac_zero_d;

  always_comb begin
    state_d   = state_q;
    chunk_d   = chunk_q;
    neuron_d  = neuron_q;
    relu_d    = relu_q;
    in_addr_d = in_addr_q;
    w_addr_d  = w_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          relu_d    = relu_en;
          neuron_d  = '0;
          in_addr_d = '0;
          w_addr_d  = '0;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        chunk_d = '0;
        state_d = S_STREAM;
        if (LAST_CHUNK != '0) begin
          in_addr_d = in_addr_q + 1'b1;
          w_addr_d  = w_addr_q + 1'b1;
        end
      end
      S_STREAM: begin
        if (chunk_q == LAST_CHUNK) begin
          state_d = S_DRAIN;
        end else begin
          chunk_d = chunk_q + 1'b1;
          // The address issued now feeds the next chunk; the last one is held.
          if (chunk_q + 1'b1 != LAST_CHUNK) begin
            in_addr_d = in_addr_q + 1'b1;
            w_addr_d  = w_addr_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (neuron_q == LAST_NEURON) begin
          state_d = S_DONE;
        end else begin
          neuron_d  = neuron_q + 1'b1;
          in_addr_d = '0;
          w_addr_d  = w_addr_q + 1'b1;
          state_d   = S_CLEAR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    mac_reset_d = (state_d == S_IDLE) || (state_d == S_CLEAR);
    mac_zero_d  = (state_d != S_STREAM);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    wr_en_d     = (state_d == S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      chunk_q     <= '0;
      neuron_q    <= '0;
      relu_q      <= 1'b0;
      in_addr_q   <= '0;
      w_addr_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      mac_reset_q <= 1'b1;
      mac_zero_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      chunk_q     <= chunk_d;
      neuron_q    <= neuron_d;
      relu_q      <= relu_d;
      in_addr_q   <= in_addr_d;
      w_addr_q    <= w_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_en_q     <= wr_en_d;
      mac_reset_q <= mac_reset_d;
      mac_zero_q  <= mac_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign in_rd_addr  = in_addr_q;
  assign w_rd_addr   = w_addr_q;
  assign mac_reset   = mac_reset_q;
  assign mac_zero    = mac_zero_q;
  assign out_wr_en   = wr_en_q;
  assign out_wr_addr = neuron_q;
  // mac_result is only valid during WRITE, so the data path stays combinational.
  assign out_wr_data = (wr_en_q && !(relu_q && mac_result[15])) ? mac_result : 16'sh0000;

endmodule
`default_nettype wire

// File: tb/tb_mac_layer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mac_layer_ctrl : directed bench with a behavioural MAC + buffers |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mac_layer_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset   = 1'b1;
  logic start_a = 1'b0;
  logic relu_a  = 1'b0;
  logic start_b = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: 2 chunks x 2 neurons, driven through a MAC model.
  logic              busy_a, done_a, mac_reset_a, mac_zero_a, wr_en_a;
  logic [3:0]        in_addr_a;
  logic [9:0]        w_addr_a;
  logic [5:0]        wr_addr_a;
  logic signed [15:0] wr_data_a;
  logic signed [15:0] mac_res_a;

  mac_layer_ctrl #(.NUM_CHUNKS(2), .NUM_NEURONS(2), .CHUNK_AW(4), .WEIGHT_AW(10), .OUT_AW(6)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .relu_en(relu_a),
    .busy(busy_a), .done(done_a), .in_rd_addr(in_addr_a), .w_rd_addr(w_addr_a),
    .mac_reset(mac_reset_a), .mac_zero(mac_zero_a), .mac_result(mac_res_a),
    .out_wr_en(wr_en_a), .out_wr_addr(wr_addr_a), .out_wr_data(wr_data_a)
  );

  // Instance B: 3 chunks x 2 neurons, used for address/control sequencing.
  logic              busy_b, done_b, mac_reset_b, mac_zero_b, wr_en_b;
  logic [3:0]        in_addr_b;
  logic [9:0]        w_addr_b;
  logic [5:0]        wr_addr_b;
  logic signed [15:0] wr_data_b;
  logic signed [15:0] mac_res_b = 16'sh0000;

  mac_layer_ctrl #(.NUM_CHUNKS(3), .NUM_NEURONS(2), .CHUNK_AW(4), .WEIGHT_AW(10), .OUT_AW(6)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .relu_en(1'b0),
    .busy(busy_b), .done(done_b), .in_rd_addr(in_addr_b), .w_rd_addr(w_addr_b),
    .mac_reset(mac_reset_b), .mac_zero(mac_zero_b), .mac_result(mac_res_b),
    .out_wr_en(wr_en_b), .out_wr_addr(wr_addr_b), .out_wr_data(wr_data_b)
  );

  // Behavioural buffers (1-cycle read) and 64-lane MAC with all lanes equal.
  logic signed [15:0] in_mem [0:15];
  logic signed [15:0] w_mem  [0:15];
  logic signed [15:0] in_q, w_q;
  logic signed [31:0] prod, acc;

  assign prod = 32'(in_q) * 32'(w_q);

  always @(posedge clk) begin
    in_q <= in_mem[in_addr_a];
    w_q  <= w_mem[w_addr_a[3:0]];
    if (mac_reset_a) acc <= 32'sd0;
    else if (!mac_zero_a) acc <= acc + (prod <<< 6);
    mac_res_a <= acc[23:8];
  end

  logic [15:0] got_data [0:7];
  logic [5:0]  got_addr [0:7];
  int          got_wr;
  int          done_k;

  task automatic fill(input logic [15:0] din, input logic [15:0] wgt, input bit ramp);
    for (int i = 0; i < 16; i++) begin
      in_mem[i] = din;
      w_mem[i]  = ramp ? 16'(i + 1) : wgt;
    end
  endtask

  // k counts cycles after the accept cycle; done is expected at k = 2*(2+3)+1 = 11.
  task automatic run_a(input logic relu, input bit spam);
    @(negedge clk); start_a = 1'b1; relu_a = relu;
    @(negedge clk); start_a = 1'b0; relu_a = ~relu;
    got_wr = 0;
    done_k = -1;
    for (int k = 1; k <= 40 && done_k < 0; k++) begin
      if (k > 1) @(negedge clk);
      if (wr_en_a) begin
        if (got_wr < 8) begin
          got_data[got_wr] = wr_data_a;
          got_addr[got_wr] = wr_addr_a;
        end
        got_wr++;
      end
      if (done_a) done_k = k;
      if (spam) start_a = k[0];
    end
    if (start_a) begin @(negedge clk); start_a = 1'b0; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if ({busy_a, done_a, wr_en_a} !== 3'b000) begin n_err++;
      $display("FAIL reset_flags: got %b want 000", {busy_a, done_a, wr_en_a}); end
    n_vec++; if ({mac_reset_a, mac_zero_a} !== 2'b11) begin n_err++;
      $display("FAIL reset_mac: got %b want 11", {mac_reset_a, mac_zero_a}); end
    n_vec++; if ({in_addr_a, w_addr_a, wr_addr_a, wr_data_a} !== 36'h0) begin n_err++;
      $display("FAIL reset_addr_data: got %h want 0", {in_addr_a, w_addr_a, wr_addr_a, wr_data_a}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    fill(16'h0100, 16'h0080, 1'b0);
    run_a(1'b0, 1'b0);
    n_vec++; if (done_k !== 11) begin n_err++;
      $display("FAIL basic_done_cycle: got %0d want 11", done_k); end
    n_vec++; if (got_wr !== 2) begin n_err++;
      $display("FAIL basic_write_count: got %0d want 2", got_wr); end
    n_vec++; if ({got_addr[0], got_data[0]} !== {6'd0, 16'h4000}) begin n_err++;
      $display("FAIL basic_write0: got %0d/%h want 0/4000", got_addr[0], got_data[0]); end
    n_vec++; if ({got_addr[1], got_data[1]} !== {6'd1, 16'h4000}) begin n_err++;
      $display("FAIL basic_write1: got %0d/%h want 1/4000", got_addr[1], got_data[1]); end
  endtask

  task automatic test_relu();
    fill(16'h0100, 16'hFF80, 1'b0);
    run_a(1'b1, 1'b0);
    n_vec++; if ({got_wr[3:0], got_data[0], got_data[1]} !== {4'd2, 16'h0000, 16'h0000}) begin n_err++;
      $display("FAIL relu_on: got n=%0d %h %h want n=2 0000 0000", got_wr, got_data[0], got_data[1]); end
    run_a(1'b0, 1'b0);
    n_vec++; if ({got_wr[3:0], got_data[0], got_data[1]} !== {4'd2, 16'hC000, 16'hC000}) begin n_err++;
      $display("FAIL relu_off: got n=%0d %h %h want n=2 c000 c000", got_wr, got_data[0], got_data[1]); end
  endtask

  // Weights row r = r+1: neuron0 sums rows 0,1 -> 64*3, neuron1 rows 2,3 -> 64*7.
  task automatic test_weight_rows();
    fill(16'h0100, 16'h0000, 1'b1);
    run_a(1'b0, 1'b0);
    n_vec++; if ({got_data[0], got_data[1]} !== {16'h00C0, 16'h01C0}) begin n_err++;
      $display("FAIL weight_rows: got %h %h want 00c0 01c0", got_data[0], got_data[1]); end
  endtask

  task automatic test_addr_seq();
    int exp_off [0:5] = '{0, 1, 2, 2, 2, 2};
    logic [16:0] got, exp;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      int j, n;
      if (k > 1) @(negedge clk);
      j = (k - 1) % 6;
      n = (k - 1) / 6;
      got = {in_addr_b, w_addr_b, mac_reset_b, mac_zero_b, wr_en_b};
      if (k <= 12)
        exp = {4'(exp_off[j]), 10'(n * 3 + exp_off[j]), (j == 0), !(j >= 1 && j <= 3), (j == 5)};
      else
        exp = {4'd2, 10'd5, (k == 14), 1'b1, 1'b0};
      n_vec++; if (got !== exp) begin n_err++;
        $display("FAIL addr_seq k=%0d: got in/w/rst/zero/we %h want %h", k, got, exp); end
      if (k == 6 || k == 12) begin
        n_vec++; if (wr_addr_b !== 6'(n)) begin n_err++;
          $display("FAIL addr_seq_wr_addr k=%0d: got %0d want %0d", k, wr_addr_b, n); end
      end
      if (k >= 13) begin
        n_vec++; if ({done_b, busy_b} !== {(k == 13), 1'b0}) begin n_err++;
          $display("FAIL addr_seq_done k=%0d: got %b want %b", k, {done_b, busy_b}, {(k == 13), 1'b0}); end
      end
    end
  endtask

  task automatic test_mid_reset();
    int bad;
    fill(16'h0100, 16'h0080, 1'b0);
    @(negedge clk); start_a = 1'b1; relu_a = 1'b0;
    @(negedge clk); start_a = 1'b0;
    repeat (6) @(negedge clk);
    n_vec++; if ({busy_a, mac_zero_a} !== 2'b10) begin n_err++;
      $display("FAIL midreset_streaming: got %b want 10", {busy_a, mac_zero_a}); end
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if ({busy_a, wr_en_a, done_a, mac_reset_a} !== 4'b0001) begin n_err++;
      $display("FAIL midreset_abort: got %b want 0001", {busy_a, wr_en_a, done_a, mac_reset_a}); end
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wr_en_a || done_a || busy_a) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++;
      $display("FAIL midreset_quiet: got %0d active cycles want 0", bad); end
    run_a(1'b0, 1'b0);
    n_vec++; if ({done_k[7:0], got_wr[3:0], got_data[0], got_data[1]} !== {8'd11, 4'd2, 16'h4000, 16'h4000}) begin n_err++;
      $display("FAIL midreset_rerun: got k=%0d n=%0d %h %h want k=11 n=2 4000 4000",
               done_k, got_wr, got_data[0], got_data[1]); end
  endtask

  task automatic test_start_spam();
    fill(16'h0100, 16'h0080, 1'b0);
    run_a(1'b0, 1'b1);
    n_vec++; if ({done_k[7:0], got_wr[3:0], got_data[0], got_data[1]} !== {8'd11, 4'd2, 16'h4000, 16'h4000}) begin n_err++;
      $display("FAIL spam_run: got k=%0d n=%0d %h %h want k=11 n=2 4000 4000",
               done_k, got_wr, got_data[0], got_data[1]); end
    @(negedge clk);
    n_vec++; if ({busy_a, mac_reset_a} !== 2'b01) begin n_err++;
      $display("FAIL spam_idle_after: got %b want 01", {busy_a, mac_reset_a}); end
  endtask

  task automatic test_back_to_back();
    fill(16'h0100, 16'h0000, 1'b1);
    run_a(1'b0, 1'b0);
    run_a(1'b0, 1'b0);
    n_vec++; if ({done_k[7:0], got_wr[3:0], got_data[0], got_data[1]} !== {8'd11, 4'd2, 16'h00C0, 16'h01C0}) begin n_err++;
      $display("FAIL back_to_back: got k=%0d n=%0d %h %h want k=11 n=2 00c0 01c0",
               done_k, got_wr, got_data[0], got_data[1]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_weight_rows();
    test_addr_seq();
    test_mid_reset();
    test_start_spam();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
